// File: rtl/simon_seq_ctrl_if.sv
// Signal bundle between simon_seq_ctrl and its game environment
// (encoder, random source, display/sound, pulse timer).
interface simon_seq_ctrl_if #(
   parameter int COLOR_W = 2,
   parameter int DEPTH   = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic               START_GAME;
   logic [COLOR_W-1:0] RAND;
   logic [COLOR_W-1:0] IN;
   logic               IN_VALID;
   logic               TIMER_PULSE;
   logic               TIMER_GO;
   logic [COLOR_W-1:0] OUT;
   logic               OUT_ENA;
   logic               WIN;
   logic               LOSE;
   logic               HS;
   logic [CNT_W-1:0]   SCORE;
   logic [CNT_W-1:0]   HIGH_SCORE;

   modport master (
      output START_GAME, RAND, IN, IN_VALID, TIMER_PULSE,
      input  TIMER_GO, OUT, OUT_ENA, WIN, LOSE, HS, SCORE, HIGH_SCORE
   );

   modport slave (
      input  START_GAME, RAND, IN, IN_VALID, TIMER_PULSE,
      output TIMER_GO, OUT, OUT_ENA, WIN, LOSE, HS, SCORE, HIGH_SCORE
   );
endinterface

// File: rtl/simon_seq_ctrl.sv
// Sequence-memory game controller: grows, plays back and checks a colour sequence.
// Optional per-input timeout enabled by defining CTRL_INPUT_TIMEOUT_EN.
module simon_seq_ctrl #(
   parameter int COLOR_W        = 2,
   parameter int DEPTH          = 32,
   parameter int TIMEOUT_PULSES = 4
) (
   input logic             CLK,
   input logic             RST_N,
   simon_seq_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_PULSES < 1) begin : g_bad_param
      $error("simon_seq_ctrl: DEPTH must be a power of two >= 2, TIMEOUT_PULSES >= 1");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_ADD, S_SHOW, S_SHOW_WAIT, S_GAP, S_INPUT, S_WIN, S_LOSE, S_END
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [COLOR_W-1:0] r_stack [DEPTH];
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0]   r_idx, w_idx_nxt;
   logic [COLOR_W-1:0] r_out, w_out_nxt;
   logic               r_ena, w_ena_nxt;
   logic               r_go, w_go_nxt;
   logic               r_win, w_win_nxt;
   logic               r_lose, w_lose_nxt;
   logic               r_hs, w_hs_nxt;
   logic [CNT_W-1:0]   r_score, w_score_nxt;
   logic [CNT_W-1:0]   r_hi, w_hi_nxt;
   logic               w_wr_en;
   logic [COLOR_W-1:0] w_cur;
   logic               w_last;

`ifdef CTRL_INPUT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_PULSES + 1);
   logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
`endif

   assign w_cur  = r_stack[r_idx[IDX_W-1:0]];
   assign w_last = (r_idx == r_cnt - CNT_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_out_nxt   = r_out;
      w_ena_nxt   = r_ena;
      w_go_nxt    = 1'b0;
      w_win_nxt   = r_win;
      w_lose_nxt  = r_lose;
      w_hs_nxt    = 1'b0;
      w_score_nxt = r_score;
      w_hi_nxt    = r_hi;
      w_wr_en     = 1'b0;
`ifdef CTRL_INPUT_TIMEOUT_EN
      w_tmo_nxt   = r_tmo;
`endif
      case (r_state)
         S_IDLE: begin
            w_ena_nxt = 1'b0;
            w_idx_nxt = '0;
            w_cnt_nxt = '0;
            if (bus.START_GAME) begin
               w_score_nxt = '0;
               w_win_nxt   = 1'b0;
               w_lose_nxt  = 1'b0;
               w_state_nxt = S_ADD;
            end
         end
         S_ADD: begin
            if (r_cnt == CNT_W'(DEPTH)) begin
               w_state_nxt = S_WIN;
            end else begin
               w_wr_en     = 1'b1;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               w_idx_nxt   = '0;
               w_state_nxt = S_SHOW;
            end
         end
         S_SHOW: begin
            w_out_nxt   = w_cur;
            w_ena_nxt   = 1'b1;
            w_go_nxt    = 1'b1;
            w_state_nxt = S_SHOW_WAIT;
         end
         S_SHOW_WAIT: begin
            if (bus.TIMER_PULSE) begin
               w_ena_nxt   = 1'b0;
               w_go_nxt    = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (bus.TIMER_PULSE) begin
               if (w_last) begin
                  w_idx_nxt   = '0;
                  w_go_nxt    = 1'b1;
                  w_state_nxt = S_INPUT;
`ifdef CTRL_INPUT_TIMEOUT_EN
                  w_tmo_nxt   = '0;
`endif
               end else begin
                  w_idx_nxt   = r_idx + CNT_W'(1);
                  w_state_nxt = S_SHOW;
               end
            end
         end
         S_INPUT: begin
            // A coincident timer pulse loses to IN_VALID and the timeout restarts.
            if (bus.IN_VALID) begin
               if (bus.IN != w_cur) begin
                  w_state_nxt = S_LOSE;
               end else if (w_last) begin
                  w_score_nxt = r_cnt;
                  w_state_nxt = S_ADD;
               end else begin
                  w_idx_nxt = r_idx + CNT_W'(1);
                  w_go_nxt  = 1'b1;
`ifdef CTRL_INPUT_TIMEOUT_EN
                  w_tmo_nxt = '0;
`endif
               end
            end
`ifdef CTRL_INPUT_TIMEOUT_EN
            else if (bus.TIMER_PULSE) begin
               if (r_tmo == TMO_W'(TIMEOUT_PULSES - 1)) begin
                  w_state_nxt = S_LOSE;
               end else begin
                  w_tmo_nxt = r_tmo + TMO_W'(1);
               end
            end
`endif
         end
         S_WIN: begin
            w_win_nxt   = 1'b1;
            w_state_nxt = S_END;
         end
         S_LOSE: begin
            w_lose_nxt  = 1'b1;
            w_state_nxt = S_END;
         end
         S_END: begin
            if (r_score > r_hi) begin
               w_hi_nxt = r_score;
               w_hs_nxt = 1'b1;
            end
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_out   <= '1;
         r_ena   <= 1'b0;
         r_go    <= 1'b0;
         r_win   <= 1'b0;
         r_lose  <= 1'b0;
         r_hs    <= 1'b0;
         r_score <= '0;
         r_hi    <= '0;
`ifdef CTRL_INPUT_TIMEOUT_EN
         r_tmo   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_out   <= w_out_nxt;
         r_ena   <= w_ena_nxt;
         r_go    <= w_go_nxt;
         r_win   <= w_win_nxt;
         r_lose  <= w_lose_nxt;
         r_hs    <= w_hs_nxt;
         r_score <= w_score_nxt;
         r_hi    <= w_hi_nxt;
`ifdef CTRL_INPUT_TIMEOUT_EN
         r_tmo   <= w_tmo_nxt;
`endif
      end
   end

   // Sequence storage carries no reset; only entries below cnt are ever read.
   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_stack[r_cnt[IDX_W-1:0]] <= bus.RAND;
      end
   end

   assign bus.TIMER_GO   = r_go;
   assign bus.OUT        = r_out;
   assign bus.OUT_ENA    = r_ena;
   assign bus.WIN        = r_win;
   assign bus.LOSE       = r_lose;
   assign bus.HS         = r_hs;
   assign bus.SCORE      = r_score;
   assign bus.HIGH_SCORE = r_hi;
endmodule
